booth_mul_seq: RTL and testbench

- Multi-cycle signed multiplier for the ALU MUL operation, and the inverse operation to the DIV unit.
- Computes A×B in two's complement using radix-4 (modified) Booth recoding, one recoded digit per clock.
- The 64-bit product is placed on Z: low word Z[31:0] goes to LO, high word Z[63:32] goes to HI, the same {HI,LO} packing DIV uses.
- A start/busy/done handshake lets the control unit stall while the product is formed.

---
 rtl/booth_mul_seq.sv | 121 ++++++++++++
 tb/tb_booth_mul_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential signed multiplier using radix-4 Booth recoding, one digit per clock.
// Produces the {HI, LO} product on Z with a start/busy/done handshake.
module booth_mul_seq #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     A,
   input  logic [DATA_WIDTH-1:0]     B,
   output logic                      busy,
   output logic                      done,
   output logic [2*DATA_WIDTH-1:0]   Z
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned ACC_W = W + 2;
   localparam int unsigned MUL_W = W + 1;
   localparam int unsigned P_W   = ACC_W + MUL_W;
   localparam int unsigned STEPS = W / 2;
   localparam int unsigned CNT_W = $clog2(STEPS + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [MUL_W-1:0] mul_q, mul_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]   z_q, z_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [ACC_W-1:0] mc_ext;
   logic [ACC_W-1:0] pp;
   logic [ACC_W-1:0] acc_sum;
   logic [P_W-1:0]   p_shift;

   // One Booth step: recode the low three multiplier bits, add the multiple, shift by 2
   always_comb begin
      mc_ext = {{2{mcand_q[W-1]}}, mcand_q};
      pp     = '0;
      case (mul_q[2:0])
         3'b001, 3'b010: pp = mc_ext;
         3'b011:         pp = ACC_W'(mc_ext << 1);
         3'b100:         pp = ACC_W'(-(mc_ext << 1));
         3'b101, 3'b110: pp = ACC_W'(-mc_ext);
         default:        pp = '0;
      endcase
      acc_sum = ACC_W'(acc_q + pp);
      p_shift = P_W'($signed({acc_sum, mul_q}) >>> 2);
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      mul_d   = mul_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_CALC;
               mcand_d = A;
               mul_d   = {B, 1'b0};
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            acc_d = p_shift[P_W-1:MUL_W];
            mul_d = p_shift[MUL_W-1:0];
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               // Bit 0 is the retired b[-1] slot; the product sits just above it
               state_d = S_DONE;
               z_d     = p_shift[2*W:1];
               done_d  = 1'b1;
            end else begin
               cnt_d  = CNT_W'(cnt_q + 1'b1);
               busy_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         mul_q   <= '0;
         cnt_q   <= '0;
         z_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         mul_q   <= mul_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Z    = z_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: stimulus queues expected products,
// a negedge monitor pops and checks them whenever done is presented.
module tb_booth_mul_seq;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           busy;
   logic           done;
   logic [2*W-1:0] Z;

   typedef struct {
      logic [63:0] z;
      int          c;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        done_prev = 1'b0;
   logic [63:0] last_z = '0;

   booth_mul_seq #(.DATA_WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Z     (Z)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            check64("product", Z, mon_e.z);
            check64("latency", 64'(cyc - mon_e.c), 64'(W / 2));
            check64("busy_at_done", {63'b0, busy}, 64'd0);
         end
         check64("done_width", {63'b0, done_prev}, 64'd0);
      end
      done_prev = done;
   end

   // Drive a request now; the following edge captures it
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] ez);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back('{ez, cyc});
      start  = 1'b0;
      last_z = ez;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 40);
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done expected done within 40 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [31:0]        va[8];
   logic [31:0]        vb[8];
   logic [63:0]        vz[8];
   logic signed [63:0] ra, rb;
   logic [31:0]        ua, ub;

   initial begin
      va[0] = 32'd7;          vb[0] = 32'hFFFFFFFD;   vz[0] = 64'hFFFFFFFF_FFFFFFEB;
      va[1] = 32'hFFFFFFFF;   vb[1] = 32'hFFFFFFFF;   vz[1] = 64'h00000000_00000001;
      va[2] = 32'h80000000;   vb[2] = 32'h80000000;   vz[2] = 64'h40000000_00000000;
      va[3] = 32'h7FFFFFFF;   vb[3] = 32'h7FFFFFFF;   vz[3] = 64'h3FFFFFFF_00000001;
      va[4] = 32'h80000000;   vb[4] = 32'h7FFFFFFF;   vz[4] = 64'hC0000000_80000000;
      va[5] = 32'd0;          vb[5] = 32'h80000000;   vz[5] = 64'h0;
      va[6] = 32'hDEADBEEF;   vb[6] = 32'd0;          vz[6] = 64'h0;
      va[7] = 32'hFFFFFFFF;   vb[7] = 32'h80000000;   vz[7] = 64'h00000000_80000000;

      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check64("reset_busy", {63'b0, busy}, 64'd0);
      check64("reset_done", {63'b0, done}, 64'd0);
      check64("reset_z", Z, 64'd0);
      idle_cycle();
      check64("idle_z", Z, 64'd0);

      // Directed vectors: first two from idle, the rest back-to-back
      for (int i = 0; i < 8; i++) begin
         issue(va[i], vb[i], vz[i]);
         wait_done();
         if (i < 2) idle_cycle();
      end
      idle_cycle();
      idle_cycle();
      check64("z_hold", Z, last_z);

      // start held and operands scrambled while busy; second op launched in the done cycle
      issue(32'h00001234, 32'h00000010, 64'h00000000_00012340);
      for (int i = 0; i < 14; i++) begin
         A     = $urandom;
         B     = $urandom;
         start = 1'b1;
         idle_cycle();
      end
      start = 1'b0;
      wait_done();
      issue(32'hFFFFFFFB, 32'd6, 64'hFFFFFFFF_FFFFFFE2);
      wait_done();
      idle_cycle();

      // Abort mid-operation with reset
      issue(32'd5, 32'd9, 64'd45);
      repeat (8) idle_cycle();
      rst = 1'b1;
      sb.delete();
      idle_cycle();
      rst = 1'b0;
      check64("abort_busy", {63'b0, busy}, 64'd0);
      check64("abort_done", {63'b0, done}, 64'd0);
      check64("abort_z", Z, 64'd0);
      issue(32'd12, 32'd12, 64'h00000000_00000090);
      wait_done();
      idle_cycle();

      // Signed sweep against a 64-bit reference product
      for (int i = 0; i < 1500; i++) begin
         ua = $urandom;
         ub = $urandom;
         ra = $signed(ua);
         rb = $signed(ub);
         issue(ua, ub, 64'(ra * rb));
         wait_done();
      end
      repeat (3) idle_cycle();
      check64("final_hold", Z, last_z);
      check64("final_busy", {63'b0, busy}, 64'd0);
      check64("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
